// File: rtl/fifo_mem_param_if.sv
// Handshake and status bundle between the parametrised FIFO and its producer/consumer.
interface fifo_mem_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_almost_full;
    logic                  fifo_almost_empty;
    logic                  fifo_overflow;
    logic                  fifo_underflow;

    modport master (
        output wr, rd, data_in, err_clr,
        input  data_out, data_valid, fifo_count, fifo_full, fifo_empty,
               fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  wr, rd, data_in, err_clr,
        output data_out, data_valid, fifo_count, fifo_full, fifo_empty,
               fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_mem_param.sv
// Parametrised synchronous FIFO with thresholds, occupancy count and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_mem_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_mem_param_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] L_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] L_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_full   = (r_count == L_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.wr && !w_full;
    assign w_rd_acc = bus.rd && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end

    // Pointers carry a wrap bit so full/empty never alias; count is kept explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + L_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + L_ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + L_ONE;
                2'b01:   r_count <= r_count - L_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error in the same cycle as err_clr must survive the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !bus.err_clr) || (bus.wr && w_full);
            r_udf <= (r_udf && !bus.err_clr) || (bus.rd && w_empty);
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out   = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign bus.data_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_dout_p1;
    logic                  r_vld_p1;

    // Registered read stage: data appears the cycle after the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_acc;
            if (w_rd_acc) r_dout_p1 <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    assign bus.data_out   = r_dout_p1;
    assign bus.data_valid = r_vld_p1;
`endif

    assign bus.fifo_count        = r_count;
    assign bus.fifo_full         = w_full;
    assign bus.fifo_empty        = w_empty;
    assign bus.fifo_almost_full  = (r_count >= L_AF);
    assign bus.fifo_almost_empty = (r_count <= L_AE);
    assign bus.fifo_overflow     = r_ovf;
    assign bus.fifo_underflow    = r_udf;
endmodule
